fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined MIPS core, generalising the PC register and the single IF/ID latch into a PC generator feeding a DEPTH-entry prefetch FIFO. Fetch runs ahead of decode while space remains, so decode stalls no longer freeze the PC. A redirect input (branch/jump resolved in ID) flushes the queued wrong-path instructions. It sits between instruction memory and the ID stage and replaces the PC plus IF_ID pair.

---
 rtl/fetch_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator feeding a DEPTH-entry prefetch FIFO
// that decouples instruction memory from the ID stage; redirect flushes wrong-path entries.
module fetch_queue #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic [ADDR_W-1:0]            imem_addr,
  output logic                         imem_req,
  input  logic [DATA_W-1:0]            imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         deq_ready,
  output logic                         deq_valid,
  output logic [DATA_W-1:0]            deq_inst,
  output logic [ADDR_W-1:0]            deq_pc4,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_queue: RESET_PC must be word-aligned");
  end

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return pc & ~ADDR_W'(3);
  endfunction

  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] fpc_inc;
  logic [PW-1:0]     rptr;
  logic [PW-1:0]     wptr;
  logic [CW-1:0]     count_nxt;
  logic              deq;
  logic              space;
  logic              enq;

  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pc4_q  [DEPTH];

  assign fpc_inc   = pc_inc(fpc);
  assign deq_valid = (count != '0);
  assign deq       = deq_valid & deq_ready;
  // A same-cycle dequeue frees the slot, so a full queue can still accept.
  assign space     = (count < FULL) | deq;
  assign enq       = space & ~redirect;

  assign imem_req  = enq;
  assign imem_addr = fpc;
  assign deq_inst  = inst_q[rptr];
  assign deq_pc4   = pc4_q[rptr];

  always_comb begin
    count_nxt = count;
    case ({enq, deq})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Fetch stage: PC and queue pointers; redirect wins over enqueue/dequeue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc   <= RESET_PC;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (redirect) begin
      fpc   <= align_pc(redirect_pc);
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        fpc  <= fpc_inc;
        wptr <= wptr + PW'(1);
      end
      if (deq) begin
        rptr <= rptr + PW'(1);
      end
      count <= count_nxt;
    end
  end

  // Queue storage: cleared on reset so the head reads zero until first fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc4_q[i]  <= '0;
      end
    end else if (enq) begin
      inst_q[wptr] <= imem_rdata;
      pc4_q[wptr]  <= fpc_inc;
    end
  end

endmodule
